// File: rtl/bunch_marker_trigger_generator_multichannel_if.sv
// Bundle between the bunch-marker trigger generator and its controller:
// the revo input, marker configuration, the trigger pulse and status.
interface bunch_marker_trigger_generator_multichannel_if #(
  parameter int NUM_MARKERS  = 4,
  parameter int BUCKET_WIDTH = 11,
  parameter int COUNT_WIDTH  = 32
);
  logic                                  revo;
  logic                                  xrm_trigger_enabled;
  logic [4:0]                            trig_prescale_N_log2;
  logic [NUM_MARKERS*BUCKET_WIDTH-1:0]   config_position;
  logic [NUM_MARKERS*9-1:0]              config_revo_mask;
  logic [NUM_MARKERS*COUNT_WIDTH-1:0]    config_desired_quantity;
  logic [NUM_MARKERS-1:0]                config_clear;
  logic                                  xrm_trigger;
  logic [NUM_MARKERS-1:0]                trigger_vector;
  logic [NUM_MARKERS*COUNT_WIDTH-1:0]    trigger_count;
  logic [NUM_MARKERS-1:0]                quantity_reached;
  logic [BUCKET_WIDTH-1:0]               bucket;
  logic [3:0]                            frame9;
  logic                                  revo_locked;
  logic [15:0]                           missed_revo_count;

  modport master (
    output revo, xrm_trigger_enabled, trig_prescale_N_log2, config_position,
           config_revo_mask, config_desired_quantity, config_clear,
    input  xrm_trigger, trigger_vector, trigger_count, quantity_reached,
           bucket, frame9, revo_locked, missed_revo_count
  );

  modport slave (
    input  revo, xrm_trigger_enabled, trig_prescale_N_log2, config_position,
           config_revo_mask, config_desired_quantity, config_clear,
    output xrm_trigger, trigger_vector, trigger_count, quantity_reached,
           bucket, frame9, revo_locked, missed_revo_count
  );
endinterface

// File: rtl/bunch_marker_trigger_generator_multichannel.sv
// N-channel bunch-marker trigger generator: tracks revo lock, free-wheels the
// bucket/frame9 counters and emits prescaled, quantity-limited triggers.
module bunch_marker_trigger_generator_multichannel #(
  parameter int NUM_MARKERS  = 4,
  parameter int BUCKET_WIDTH = 11,
  parameter int REVO_PERIOD  = 1280,
  parameter int LOCK_COUNT   = 4,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic clock,
  input  logic reset,
  bunch_marker_trigger_generator_multichannel_if.slave bus
);
  localparam logic [BUCKET_WIDTH-1:0] LAST_BUCKET = BUCKET_WIDTH'(REVO_PERIOD - 1);
  localparam int ON_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRING, LOCKED} lock_state_e;

  lock_state_e             state, state_next;
  logic [ON_W-1:0]         on_time, on_time_next;
  logic                    lose_lock;
  logic                    revo_q, revo_q_d, revo_event;
  logic [BUCKET_WIDTH-1:0] bucket;
  logic [3:0]              frame9;
  logic [15:0]             missed_revo_count;
  logic                    at_last, on_time_revo, early_revo, missed_wrap;

  logic [COUNT_WIDTH-1:0]  match_count     [NUM_MARKERS];
  logic [COUNT_WIDTH-1:0]  trigger_count_r [NUM_MARKERS];
  logic [NUM_MARKERS-1:0]  match, fire, quantity_reached;
  logic [NUM_MARKERS-1:0]  trigger_vector_r;
  logic                    xrm_trigger_r;
  logic [COUNT_WIDTH-1:0]  prescale_mask;
  logic [NUM_MARKERS*COUNT_WIDTH-1:0] trigger_count_flat;

  assign at_last      = (bucket == LAST_BUCKET);
  assign on_time_revo = revo_event && at_last;
  assign early_revo   = revo_event && !at_last;
  assign missed_wrap  = at_last && !revo_event;

  // Revo is registered, edge-detected, and the edge itself registered, so the
  // bucket restart lands two edges after revo is first sampled.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      revo_q     <= 1'b0;
      revo_q_d   <= 1'b0;
      revo_event <= 1'b0;
    end else begin
      revo_q     <= bus.revo;
      revo_q_d   <= revo_q;
      revo_event <= revo_q && !revo_q_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= UNLOCKED;
      on_time           <= '0;
      bucket            <= '0;
      frame9            <= '0;
      missed_revo_count <= '0;
    end else begin
      state   <= state_next;
      on_time <= on_time_next;
      if (revo_event || at_last) begin
        bucket <= '0;
        frame9 <= (frame9 == 4'd8) ? 4'd0 : frame9 + 4'd1;
      end else begin
        bucket <= bucket + BUCKET_WIDTH'(1);
      end
      if (lose_lock && missed_revo_count != 16'hFFFF)
        missed_revo_count <= missed_revo_count + 16'd1;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through the
  // case can leave it unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    on_time_next = on_time;
    lose_lock    = 1'b0;
    unique case (state)
      UNLOCKED: if (revo_event) begin
        on_time_next = ON_W'(1);
        state_next   = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRING;
      end
      ACQUIRING: begin
        if (on_time_revo) begin
          on_time_next = on_time + ON_W'(1);
          if (int'(on_time) + 1 >= LOCK_COUNT) state_next = LOCKED;
        end else if (early_revo) begin
          on_time_next = ON_W'(1);
        end else if (missed_wrap) begin
          on_time_next = '0;
          state_next   = UNLOCKED;
        end
      end
      LOCKED: if (early_revo || missed_wrap) begin
        on_time_next = '0;
        state_next   = UNLOCKED;
        lose_lock    = 1'b1;
      end
      default: state_next = UNLOCKED;
    endcase
  end

  // A shift past the counter width yields an all-ones mask (fire on wrap only).
  assign prescale_mask = (COUNT_WIDTH'(1) << bus.trig_prescale_N_log2) - COUNT_WIDTH'(1);

  always_comb begin
    match              = '0;
    fire               = '0;
    quantity_reached   = '0;
    trigger_count_flat = '0;
    for (int i = 0; i < NUM_MARKERS; i++) begin
      match[i] = (state == LOCKED) && bus.xrm_trigger_enabled
              && (bucket == bus.config_position[i*BUCKET_WIDTH +: BUCKET_WIDTH])
              && bus.config_revo_mask[i*9 + int'(frame9)];
      quantity_reached[i] = (bus.config_desired_quantity[i*COUNT_WIDTH +: COUNT_WIDTH] != '0)
              && (trigger_count_r[i] >= bus.config_desired_quantity[i*COUNT_WIDTH +: COUNT_WIDTH]);
      fire[i] = match[i] && ((match_count[i] & prescale_mask) == '0)
              && !quantity_reached[i] && !bus.config_clear[i];
      trigger_count_flat[i*COUNT_WIDTH +: COUNT_WIDTH] = trigger_count_r[i];
    end
  end

  // NOTE: the per-marker counter arrays are plain flops, not RAM, so they take
  // the reset like any other state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      xrm_trigger_r    <= 1'b0;
      trigger_vector_r <= '0;
      for (int i = 0; i < NUM_MARKERS; i++) begin
        match_count[i]     <= '0;
        trigger_count_r[i] <= '0;
      end
    end else begin
      xrm_trigger_r    <= |fire;
      trigger_vector_r <= fire;
      for (int i = 0; i < NUM_MARKERS; i++) begin
        if (bus.config_clear[i]) begin
          match_count[i]     <= '0;
          trigger_count_r[i] <= '0;
        end else if (match[i]) begin
          match_count[i] <= match_count[i] + COUNT_WIDTH'(1);
          if (fire[i] && trigger_count_r[i] != '1)
            trigger_count_r[i] <= trigger_count_r[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.xrm_trigger       = xrm_trigger_r;
  assign bus.trigger_vector    = trigger_vector_r;
  assign bus.trigger_count     = trigger_count_flat;
  assign bus.quantity_reached  = quantity_reached;
  assign bus.bucket            = bucket;
  assign bus.frame9            = frame9;
  assign bus.revo_locked       = (state == LOCKED);
  assign bus.missed_revo_count = missed_revo_count;
endmodule

// File: tb/tb_bunch_marker_trigger_generator_multichannel.sv
// Self-checking bench: directed lock/trigger scenarios plus randomized revo
// timing and marker configuration, compared every cycle against a behavioural model.
module tb_bunch_marker_trigger_generator_multichannel;
  localparam int NM = 4;
  localparam int BW = 11;
  localparam int P  = 1280;
  localparam int LC = 4;
  localparam int CW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bunch_marker_trigger_generator_multichannel_if #(
    .NUM_MARKERS(NM), .BUCKET_WIDTH(BW), .COUNT_WIDTH(CW)) bus ();

  bunch_marker_trigger_generator_multichannel #(
    .NUM_MARKERS(NM), .BUCKET_WIDTH(BW), .REVO_PERIOD(P),
    .LOCK_COUNT(LC), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_bucket, m_frame9, m_streak, m_missed;
  bit          m_locked;
  longint      m_mc [NM];
  longint      m_tc [NM];
  bit          m_trig;
  bit [NM-1:0] m_vec;
  bit [2:0]    hist;   // [0] = revo sampled one edge ago, [2] = three edges ago

  function automatic void model_step();
    bit ev, wrap, hit, full, f;
    int pos, n;
    bit [8:0] msk;
    longint des;
    if (reset !== 1'b1) begin
      m_bucket = 0; m_frame9 = 0; m_streak = 0; m_missed = 0; m_locked = 0;
      m_trig = 0; m_vec = '0; hist = '0;
      for (int i = 0; i < NM; i++) begin m_mc[i] = 0; m_tc[i] = 0; end
      return;
    end
    ev   = hist[1] && !hist[2];
    wrap = (m_bucket == P - 1);
    n    = int'(bus.trig_prescale_N_log2);
    for (int i = 0; i < NM; i++) begin
      pos  = int'(bus.config_position[i*BW +: BW]);
      msk  = bus.config_revo_mask[i*9 +: 9];
      des  = longint'(bus.config_desired_quantity[i*CW +: CW]);
      hit  = m_locked && bus.xrm_trigger_enabled && (pos == m_bucket) && msk[m_frame9];
      full = (des != 0) && (m_tc[i] >= des);
      f    = hit && (m_mc[i] % (64'd1 << n) == 0) && !full && !bus.config_clear[i];
      m_vec[i] = f;
      if (bus.config_clear[i]) begin
        m_mc[i] = 0; m_tc[i] = 0;
      end else if (hit) begin
        m_mc[i] = (m_mc[i] + 1) % (64'd1 << CW);
        if (f && m_tc[i] < (64'd1 << CW) - 1) m_tc[i]++;
      end
    end
    m_trig = |m_vec;
    if (m_locked) begin
      if (!(ev && wrap) && (ev || wrap)) begin
        m_locked = 0; m_streak = 0;
        if (m_missed < 65535) m_missed++;
      end
    end else if (m_streak == 0) begin
      if (ev) begin m_streak = 1; m_locked = (LC <= 1); end
    end else begin
      if (ev && wrap) begin
        m_streak++;
        if (m_streak >= LC) m_locked = 1;
      end else if (ev) m_streak = 1;
      else if (wrap) m_streak = 0;
    end
    if (ev || wrap) begin
      m_bucket = 0; m_frame9 = (m_frame9 + 1) % 9;
    end else m_bucket++;
    hist = {hist[1:0], bus.revo === 1'b1};
  endfunction

  // Model steps on each edge; DUT outputs are compared 1 time unit later.
  always @(posedge clock) begin
    logic [127:0] exp_tc;
    logic [NM-1:0] exp_qr;
    model_step();
    #1;
    exp_tc = '0;
    for (int i = 0; i < NM; i++) begin
      exp_tc[i*CW +: CW] = m_tc[i][CW-1:0];
      exp_qr[i] = (bus.config_desired_quantity[i*CW +: CW] != '0)
               && (m_tc[i] >= longint'(bus.config_desired_quantity[i*CW +: CW]));
    end
    check("bucket",            bus.bucket,            128'(m_bucket));
    check("frame9",            bus.frame9,            128'(m_frame9));
    check("revo_locked",       bus.revo_locked,       128'(m_locked));
    check("missed_revo_count", bus.missed_revo_count, 128'(m_missed));
    check("xrm_trigger",       bus.xrm_trigger,       128'(m_trig));
    check("trigger_vector",    bus.trigger_vector,    128'(m_vec));
    check("trigger_count",     bus.trigger_count,     exp_tc);
    check("quantity_reached",  bus.quantity_reached,  128'(exp_qr));
  end

  // ---------------- stimulus ----------------
  function automatic logic [CW-1:0] tc_of(input int i);
    return bus.trigger_count[i*CW +: CW];
  endfunction

  // Each call starts and ends on a negedge; revo high for `width` cycles per period.
  task automatic revo_train(input int count, input int period,
                            input logic [NM-1:0] clr, input int width);
    repeat (count) begin
      bus.revo = 1'b1;
      bus.config_clear = clr;
      @(negedge clock);
      bus.config_clear = '0;
      repeat (width - 1) @(negedge clock);
      bus.revo = 1'b0;
      repeat (period - width) @(negedge clock);
    end
  endtask

  task automatic set_marker(input int i, input int pos, input logic [8:0] msk, input int des);
    bus.config_position[i*BW +: BW]         = BW'(pos);
    bus.config_revo_mask[i*9 +: 9]          = msk;
    bus.config_desired_quantity[i*CW +: CW] = CW'(des);
  endtask

  initial begin
    bit seen;
    bus.revo = 1'b0;
    bus.xrm_trigger_enabled = 1'b1;
    bus.trig_prescale_N_log2 = 5'd0;
    bus.config_clear = '0;
    bus.config_position = '0;
    bus.config_revo_mask = '0;
    bus.config_desired_quantity = '0;
    set_marker(0, 0,   9'h1FF, 0);
    set_marker(1, 100, 9'h001, 0);
    set_marker(2, 500, 9'h1FF, 3);
    set_marker(3, 500, 9'h1FF, 3);

    repeat (3) @(negedge clock);
    check("reset xrm_trigger", bus.xrm_trigger, 128'd0);
    check("reset bucket", bus.bucket, 128'd0);
    check("reset revo_locked", bus.revo_locked, 128'd0);
    check("reset trigger_count", bus.trigger_count, 128'd0);
    reset = 1'b1;
    repeat (50) @(negedge clock);

    // Lock acquisition: locked after the fourth revo; markers 0,2,3 fire once.
    revo_train(4, P, '0, 1);
    check("locked after 4 revos", bus.revo_locked, 128'd1);
    check("tc0 after lock rev", tc_of(0), 128'd1);
    check("tc2 after lock rev", tc_of(2), 128'd1);
    revo_train(2, P, '0, 1);
    check("tc0 after 3 locked revs", tc_of(0), 128'd3);
    check("tc3 at quantity", tc_of(3), 128'd3);
    check("quantity_reached 1100", bus.quantity_reached, 128'h0C);
    revo_train(2, P, '0, 1);
    check("tc0 after 5 locked revs", tc_of(0), 128'd5);
    check("tc2 held at limit", tc_of(2), 128'd3);

    // Clear marker 2: it resumes, marker 3 stays at its limit.
    revo_train(1, P, 4'b0100, 1);
    check("tc2 resumed after clear", tc_of(2), 128'd1);
    check("tc3 still at limit", tc_of(3), 128'd3);
    check("quantity_reached 1000", bus.quantity_reached, 128'h08);

    // Omitted revo: lock drops at the wrap.
    repeat (P + 20) @(negedge clock);
    check("unlocked after omission", bus.revo_locked, 128'd0);
    check("missed count 1", bus.missed_revo_count, 128'd1);
    check("tc0 frozen while unlocked", tc_of(0), 128'd6);

    // Relock, then a revo 10 cycles early.
    revo_train(3, P, '0, 1);
    revo_train(1, P - 10, '0, 1);
    revo_train(1, P, '0, 1);
    check("unlocked after early revo", bus.revo_locked, 128'd0);
    check("missed count 2", bus.missed_revo_count, 128'd2);
    check("tc0 one fire during relock", tc_of(0), 128'd7);

    // Reset asserted while a trigger pulse is on the outputs.
    revo_train(4, P, '0, 1);
    bus.revo = 1'b1;
    @(negedge clock);
    bus.revo = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (bus.xrm_trigger === 1'b1) seen = 1;
    end
    check("trigger seen before mid-run reset", 128'(seen), 128'd1);
    reset = 1'b0;
    @(negedge clock);
    check("mid reset xrm_trigger", bus.xrm_trigger, 128'd0);
    check("mid reset trigger_vector", bus.trigger_vector, 128'd0);
    check("mid reset trigger_count", bus.trigger_count, 128'd0);
    check("mid reset missed", bus.missed_revo_count, 128'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Randomized configuration and revo timing.
    for (int seg = 0; seg < 10; seg++) begin
      bus.trig_prescale_N_log2 = 5'($urandom_range(0, 2));
      bus.xrm_trigger_enabled  = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NM; i++)
        set_marker(i, $urandom_range(0, 1350), 9'($urandom), $urandom_range(0, 4));
      for (int r = 0; r < 3; r++) begin
        int kind, per;
        logic [NM-1:0] clr;
        kind = $urandom_range(0, 99);
        if (kind < 82)      per = P;
        else if (kind < 91) per = P - $urandom_range(1, 30);
        else                per = P + $urandom_range(1, 40);
        clr = ($urandom_range(0, 4) == 0) ? NM'($urandom) : '0;
        revo_train(1, per, clr, $urandom_range(1, 2));
      end
    end

    repeat (10) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
